// File: rtl/change_dispenser.sv
// Coin-change dispenser: pays a requested amount greedily from quarter, dime and
// nickel tubes through a valid/ack handshake with the coin mechanism.
module change_dispenser #(
    parameter int AMOUNT_W = 8,
    parameter int INV_MAX  = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [AMOUNT_W-1:0] AMOUNT,
    input  logic                REFILL,
    input  logic                COIN_ACK,
    output logic                COIN_VALID,
    output logic [1:0]          COIN_TYPE,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [AMOUNT_W-1:0] SHORT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_OFFER,
        S_FINISH
    } state_e;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;

    localparam logic [3:0]          INV_FULL  = 4'(INV_MAX);
    localparam logic [AMOUNT_W-1:0] VAL_NICKEL  = AMOUNT_W'(5);
    localparam logic [AMOUNT_W-1:0] VAL_DIME    = AMOUNT_W'(10);
    localparam logic [AMOUNT_W-1:0] VAL_QUARTER = AMOUNT_W'(25);

    state_e              state_q, state_d;
    logic [AMOUNT_W-1:0] rem_q, rem_d;
    logic                err_q, err_d;
    logic [1:0]          coin_type_q, coin_type_d;
    logic [3:0]          cnt_nickel_q, cnt_nickel_d;
    logic [3:0]          cnt_dime_q, cnt_dime_d;
    logic [3:0]          cnt_quarter_q, cnt_quarter_d;

    logic                sel_valid;
    logic [1:0]          sel_type;
    logic [AMOUNT_W-1:0] offer_value;
    logic                amount_bad;

    function automatic logic [AMOUNT_W-1:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_QUARTER: coin_value = VAL_QUARTER;
            COIN_DIME:    coin_value = VAL_DIME;
            default:      coin_value = VAL_NICKEL;
        endcase
    endfunction

    assign amount_bad  = (AMOUNT % VAL_NICKEL) != '0;
    assign offer_value = coin_value(coin_type_q);

    // Greedy choice: largest coin that still fits and is in stock.
    always_comb begin
        sel_valid = 1'b1;
        sel_type  = COIN_NICKEL;
        if (rem_q >= VAL_QUARTER && cnt_quarter_q != '0) begin
            sel_type = COIN_QUARTER;
        end else if (rem_q >= VAL_DIME && cnt_dime_q != '0) begin
            sel_type = COIN_DIME;
        end else if (rem_q >= VAL_NICKEL && cnt_nickel_q != '0) begin
            sel_type = COIN_NICKEL;
        end else begin
            sel_valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            err_q         <= 1'b0;
            coin_type_q   <= COIN_NICKEL;
            cnt_nickel_q  <= INV_FULL;
            cnt_dime_q    <= INV_FULL;
            cnt_quarter_q <= INV_FULL;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            err_q         <= err_d;
            coin_type_q   <= coin_type_d;
            cnt_nickel_q  <= cnt_nickel_d;
            cnt_dime_q    <= cnt_dime_d;
            cnt_quarter_q <= cnt_quarter_d;
        end
    end

    // NOTE: every next-state value gets a hold default first so no path
    // through the case statement infers a latch.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        err_d         = err_q;
        coin_type_d   = coin_type_q;
        cnt_nickel_d  = cnt_nickel_q;
        cnt_dime_d    = cnt_dime_q;
        cnt_quarter_d = cnt_quarter_q;

        case (state_q)
            S_IDLE: begin
                if (REFILL) begin
                    cnt_nickel_d  = INV_FULL;
                    cnt_dime_d    = INV_FULL;
                    cnt_quarter_d = INV_FULL;
                end
                if (START) begin
                    rem_d   = AMOUNT;
                    err_d   = amount_bad;
                    // Odd amounts still pass through SELECT so every coinless
                    // request completes with the same START-to-DONE latency.
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                if (err_q || rem_q == '0) begin
                    state_d = S_FINISH;
                end else if (!sel_valid) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    coin_type_d = sel_type;
                    state_d     = S_OFFER;
                end
            end

            S_OFFER: begin
                if (COIN_ACK) begin
                    rem_d = (rem_q >= offer_value) ? rem_q - offer_value : '0;
                    case (coin_type_q)
                        COIN_QUARTER: if (cnt_quarter_q != '0) cnt_quarter_d = cnt_quarter_q - 4'd1;
                        COIN_DIME:    if (cnt_dime_q != '0)    cnt_dime_d    = cnt_dime_q - 4'd1;
                        default:      if (cnt_nickel_q != '0)  cnt_nickel_d  = cnt_nickel_q - 4'd1;
                    endcase
                    state_d = S_SELECT;
                end
            end

            S_FINISH: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        COIN_VALID = (state_q == S_OFFER);
        COIN_TYPE  = coin_type_q;
        BUSY       = (state_q != S_IDLE);
        DONE       = (state_q == S_FINISH);
        ERR        = DONE & err_q;
        SHORT      = DONE ? rem_q : '0;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: drives requests, plays the coin
// mechanism, and compares coin sequences, completion status and tube counts.
module tb_change_dispenser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] AMOUNT = 8'd0;
    logic       REFILL = 1'b0;
    logic       COIN_ACK = 1'b0;
    logic       COIN_VALID;
    logic [1:0] COIN_TYPE;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [7:0] SHORT;

    change_dispenser #(.AMOUNT_W(8), .INV_MAX(15)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .AMOUNT     (AMOUNT),
        .REFILL     (REFILL),
        .COIN_ACK   (COIN_ACK),
        .COIN_VALID (COIN_VALID),
        .COIN_TYPE  (COIN_TYPE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR),
        .SHORT      (SHORT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] coins[$];
    int         first_lat;
    int         done_lat_start;
    int         done_lat_ack;
    int         done_err;
    int         done_short;
    bit         got_done;
    bit         stable_ok;
    bit         gap_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_tubes(input int q, input int d, input int n);
        check("tube_quarter", 32'(dut.cnt_quarter_q), q);
        check("tube_dime",    32'(dut.cnt_dime_q), d);
        check("tube_nickel",  32'(dut.cnt_nickel_q), n);
    endtask

    task automatic check_quiet_outputs();
        check("idle_valid", 32'(COIN_VALID), 0);
        check("idle_busy",  32'(BUSY), 0);
        check("idle_done",  32'(DONE), 0);
        check("idle_err",   32'(ERR), 0);
        check("idle_short", 32'(SHORT), 0);
        check("idle_type",  32'(COIN_TYPE), 0);
    endtask

    // One full request. Latencies count edges with the reference edge as 1.
    // hold: cycles the ack is withheld after COIN_VALID appears.
    // poke: drive START while the coin is on offer (must be ignored).
    task automatic pay(input logic [7:0] amt, input int hold, input bit refill, input bit poke);
        int         cyc;
        int         ack_idx;
        logic [1:0] t;
        coins.delete();
        first_lat = -1; done_lat_start = -1; done_lat_ack = -1;
        done_err = -1; done_short = -1;
        got_done = 1'b0; stable_ok = 1'b1; gap_ok = 1'b1; ack_idx = 0;
        START = 1'b1; AMOUNT = amt; REFILL = refill;
        tick();
        START = 1'b0; REFILL = 1'b0;
        cyc = 1;
        while (cyc < 400 && !got_done) begin
            if (DONE) begin
                got_done       = 1'b1;
                done_err       = 32'(ERR);
                done_short     = 32'(SHORT);
                done_lat_start = cyc;
                if (ack_idx > 0) done_lat_ack = cyc - ack_idx + 1;
            end else if (COIN_VALID) begin
                if (first_lat < 0) first_lat = cyc;
                t = COIN_TYPE;
                for (int i = 0; i < hold; i++) begin
                    if (poke) begin
                        START  = 1'b1;
                        AMOUNT = 8'd25;
                    end
                    tick();
                    cyc++;
                    if (!COIN_VALID || COIN_TYPE !== t) stable_ok = 1'b0;
                end
                START    = 1'b0;
                COIN_ACK = 1'b1;
                tick();
                cyc++;
                COIN_ACK = 1'b0;
                ack_idx  = cyc;
                coins.push_back(t);
                if (COIN_VALID) gap_ok = 1'b0;
            end else begin
                tick();
                cyc++;
            end
        end
        check("pay_done_seen", 32'(got_done), 1);
        tick();
    endtask

    int  n_dime;
    int  n_nick;
    bit  saw_done;

    initial begin
        do_reset();
        check_quiet_outputs();
        check_tubes(15, 15, 15);

        // 40 cents with prompt acks: quarter, dime, nickel.
        pay(8'd40, 0, 1'b0, 1'b0);
        check("p40_ncoins", coins.size(), 3);
        if (coins.size() == 3) begin
            check("p40_c0", 32'(coins[0]), 2);
            check("p40_c1", 32'(coins[1]), 1);
            check("p40_c2", 32'(coins[2]), 0);
        end
        check("p40_err",       done_err, 0);
        check("p40_short",     done_short, 0);
        check("p40_first_lat", first_lat, 2);
        check("p40_ack_done",  done_lat_ack, 2);
        check("p40_gap",       32'(gap_ok), 1);
        check_tubes(14, 14, 14);

        // Stray ack while idle must not touch the tubes.
        COIN_ACK = 1'b1;
        tick();
        tick();
        COIN_ACK = 1'b0;
        check("stray_busy", 32'(BUSY), 0);
        check_tubes(14, 14, 14);

        pay(8'd7, 0, 1'b0, 1'b0);
        check("p7_ncoins",   coins.size(), 0);
        check("p7_done_lat", done_lat_start, 2);
        check("p7_err",      done_err, 1);
        check("p7_short",    done_short, 7);

        pay(8'd0, 0, 1'b0, 1'b0);
        check("p0_ncoins",   coins.size(), 0);
        check("p0_done_lat", done_lat_start, 2);
        check("p0_err",      done_err, 0);
        check("p0_short",    done_short, 0);

        // Quarter depletion: 15 single quarters, then dime+dime+nickel.
        do_reset();
        for (int r = 0; r < 15; r++) begin
            pay(8'd25, 0, 1'b0, 1'b0);
            check("q25_ncoins", coins.size(), 1);
            check("q25_type", (coins.size() > 0) ? 32'(coins[0]) : 32'd3, 2);
        end
        pay(8'd25, 0, 1'b0, 1'b0);
        check("q16_ncoins", coins.size(), 3);
        if (coins.size() == 3) begin
            check("q16_c0", 32'(coins[0]), 1);
            check("q16_c1", 32'(coins[1]), 1);
            check("q16_c2", 32'(coins[2]), 0);
        end
        check("q16_err", done_err, 0);
        check_tubes(0, 13, 14);

        // 13 dimes + 14 nickels cover exactly 200 cents, so 205 leaves 5 unpaid.
        pay(8'd205, 0, 1'b0, 1'b0);
        n_dime = 0;
        n_nick = 0;
        foreach (coins[i]) begin
            if (coins[i] == 2'b01) n_dime++;
            if (coins[i] == 2'b00) n_nick++;
        end
        check("p205_ncoins", coins.size(), 27);
        check("p205_dimes",  n_dime, 13);
        check("p205_nickel", n_nick, 14);
        check("p205_err",    done_err, 1);
        check("p205_short",  done_short, 5);
        check_tubes(0, 0, 0);

        REFILL = 1'b1;
        tick();
        REFILL = 1'b0;
        check_tubes(15, 15, 15);

        pay(8'd255, 0, 1'b0, 1'b0);
        check("p255_ncoins", coins.size(), 11);
        for (int i = 0; i < 10 && i < coins.size(); i++)
            check("p255_quarter", 32'(coins[i]), 2);
        if (coins.size() == 11) check("p255_last", 32'(coins[10]), 0);
        check("p255_err", done_err, 0);
        check_tubes(5, 15, 14);

        // REFILL and START on the same edge: both take effect.
        pay(8'd25, 0, 1'b1, 1'b0);
        check("refill_start_ncoins", coins.size(), 1);
        check_tubes(14, 15, 15);

        // Ack withheld 20 cycles while START is hammered: offer stays put.
        pay(8'd10, 20, 1'b0, 1'b1);
        check("hold_stable", 32'(stable_ok), 1);
        check("hold_ncoins", coins.size(), 1);
        check("hold_type", (coins.size() > 0) ? 32'(coins[0]) : 32'd3, 1);
        check("hold_short", done_short, 0);
        check("hold_idle_after", 32'(BUSY), 0);
        check_tubes(14, 14, 15);

        // Reset lands while the second coin of 50 cents is on offer.
        START = 1'b1; AMOUNT = 8'd50;
        tick();
        START = 1'b0;
        tick();
        check("rst_offer1", 32'(COIN_VALID), 1);
        COIN_ACK = 1'b1;
        tick();
        COIN_ACK = 1'b0;
        tick();
        check("rst_offer2", 32'(COIN_VALID), 1);
        RST = 1'b1; COIN_ACK = 1'b1;
        tick();
        RST = 1'b0; COIN_ACK = 1'b0;
        check_quiet_outputs();
        check_tubes(15, 15, 15);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (DONE || BUSY) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 0);

        pay(8'd50, 0, 1'b0, 1'b0);
        check("p50_ncoins", coins.size(), 2);
        for (int i = 0; i < coins.size(); i++)
            check("p50_quarter", 32'(coins[i]), 2);
        check("p50_err", done_err, 0);
        check("p50_short", done_short, 0);
        check_tubes(13, 15, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
